cva6_cfg_reader: RTL and testbench
==================================

Name: cva6_cfg_reader

Overview:
- Read-side responder for the core configuration package: exposes every `cva6_config_pkg` value as a 32-bit word, so software and debug can discover the build configuration at run time.
- Two access paths:
  - A single-outstanding request/response read port, attached to the debug/CSR fabric.
  - A streaming dump engine that emits all words in order on a valid/ready stream, for trace/boot logging.
- Sits beside the CSR file; has no side effects on the core.

Parameters:
- DATA_W, 32, response/stream data width; values are zero-extended.
- IDX_W, 4, word-index width; must satisfy 2**IDX_W >= NUM_WORDS.

Ports:
- clk_i  in  1  core clock
- rst_ni  in  1  reset, synchronous, active-low
- req_i  in  1  read request
- idx_i  in  IDX_W  word index requested
- gnt_o  out  1  request accepted this cycle
- rvalid_o  out  1  response valid
- rdata_o  out  DATA_W  response data
- rerr_o  out  1  index out of range
- rready_i  in  1  response consumed
- dump_start_i  in  1  start-dump pulse
- dump_valid_o  out  1  stream word valid
- dump_data_o  out  DATA_W  stream word
- dump_idx_o  out  IDX_W  index of the current stream word
- dump_last_o  out  1  final word of the dump
- dump_ready_i  in  1  stream sink ready
- dump_busy_o  out  1  dump in progress

Behaviour:
- Reset: the only reset is synchronous, active-low, sampled on the rising edge of clk_i.
  - All outputs are 0 in reset; the FSM goes to IDLE.
  - Reset mid-dump or mid-response drops all state; no word is emitted afterwards.
- Word map (index: value):
  - 0: Xlen
  - 1: feature bitmap — bit0 Fpu, 1 F16, 2 F16Alt, 3 F8, 4 FVec, 5 Cvxif, 6 CExt, 7 AExt, 8 FetchUserEn, 9 DataUserEn, 10 RenameEn, 11 FPGAEn; bits 12+ are 0
  - 2: FetchUserWidth
  - 3: DataUserWidth
  - 4: IcacheSetAssoc
  - 5: DcacheSetAssoc
  - 6: NrCommitPorts
  - 7: NrScoreboardEntries
  - 8: NrLoadPipeRegs
  - 9: NrStorePipeRegs
  - 10: InstrTlbEntries
  - 11: DataTlbEntries
  - NUM_WORDS = 12.
- Read port:
  - gnt_o = req_i & (~rvalid_o | rready_i). A new request is granted in the same cycle the previous response is consumed.
  - On grant, rvalid_o rises the next cycle, carrying rdata_o = word[idx_i] and rerr_o = 0.
  - Out-of-range index (idx_i >= NUM_WORDS): rdata_o = 0, rerr_o = 1.
  - rvalid_o, rdata_o and rerr_o are held stable until rready_i is high. rvalid_o is cleared the cycle after consumption unless a new grant occurred.
- Dump FSM:
  - IDLE: on dump_start_i, load cnt = 0 and go to STREAM.
  - STREAM: dump_valid_o = 1, dump_data_o = word[cnt], dump_idx_o = cnt, dump_last_o = (cnt == NUM_WORDS-1).
    - On dump_valid_o & dump_ready_i with last set: go to IDLE.
    - On handshake otherwise: cnt increments.
    - With no handshake, outputs are held stable.
  - dump_busy_o = (state == STREAM).
  - dump_start_i while in STREAM is ignored.
  - A start pulse in the same cycle as the final handshake is ignored; the FSM returns to IDLE.
  - The counter never wraps past NUM_WORDS-1.
- Concurrency: the read port and the dump engine are fully independent. Simultaneous activity on both paths causes no stalls.
- Outputs are registered. The word table is constant combinational logic from the package.

Optional Feature:
- Macro: CVA6_CFG_SIGNATURE_EN.
- Defined:
  - Adds word 12 = 0xC0F6_0000 XOR (XOR of words 0..11), and NUM_WORDS = 13.
  - The dump emits 13 words, with dump_last_o on index 12.
  - A read of index 12 is valid.
- Undefined: NUM_WORDS = 12; index 12 returns rerr_o = 1.

Decomposition:
- Shared package cva6_cfg_reader_pkg holds:
  - NUM_WORDS
  - word-index localparams (CFG_IDX_XLEN … CFG_IDX_DTLB, CFG_IDX_SIG)
  - feature-bit position localparams
  - function cfg_word(idx) returning the word table and the signature
- Natural sub-module: cva6_cfg_dump_fsm, which owns the dump state, counter and stream handshake, and calls cfg_word().

Test Plan:
- Reset, then read idx 0 with rready_i=1 -> gnt_o same cycle; next cycle rvalid_o=1, rdata_o=32, rerr_o=0.
- Read idx 1 -> rdata_o=0x0000_0080 (only AExt set). Read idx 5 -> 8. Read idx 10 -> 16.
- Read idx 15 -> rdata_o=0, rerr_o=1. Without the macro, idx 12 -> rerr_o=1.
- Hold rready_i=0 for 3 cycles with req_i high -> gnt_o=0 and the response is stable throughout; rready_i=1 -> gnt_o=1 in that cycle.
- Pulse dump_start_i with random dump_ready_i backpressure -> words 32, 0x80, 32, 32, 4, 8, 2, 8, 1, 0, 16, 16 in order; dump_last_o only at idx 11; dump_busy_o falls the cycle after the last handshake.
- Assert rst_ni=0 mid-dump at idx 5 -> next cycle all outputs are 0 and the FSM is IDLE. With CVA6_CFG_SIGNATURE_EN, a full dump has 13 words and word 12 matches the computed XOR.

Source files
------------

// File: rtl/cva6_cfg_reader_pkg.sv
// cva6_cfg_reader_pkg: configuration word map shared by the reader and its dump engine
// Contents: NUM_WORDS, word indices, feature-bit positions, dump FSM states, cfg_word().
// Macro CVA6_CFG_SIGNATURE_EN appends a signature word at CFG_IDX_SIG (NUM_WORDS = 13).
package cva6_cfg_reader_pkg;
`ifdef CVA6_CFG_SIGNATURE_EN
  localparam int unsigned NUM_WORDS = 13;
`else
  localparam int unsigned NUM_WORDS = 12;
`endif
  localparam int unsigned CFG_IDX_XLEN   = 0;
  localparam int unsigned CFG_IDX_FEAT   = 1;
  localparam int unsigned CFG_IDX_FUSER  = 2;
  localparam int unsigned CFG_IDX_DUSER  = 3;
  localparam int unsigned CFG_IDX_ICACHE = 4;
  localparam int unsigned CFG_IDX_DCACHE = 5;
  localparam int unsigned CFG_IDX_COMMIT = 6;
  localparam int unsigned CFG_IDX_SB     = 7;
  localparam int unsigned CFG_IDX_LDPIPE = 8;
  localparam int unsigned CFG_IDX_STPIPE = 9;
  localparam int unsigned CFG_IDX_ITLB   = 10;
  localparam int unsigned CFG_IDX_DTLB   = 11;
  localparam int unsigned CFG_IDX_SIG    = 12;
  localparam int unsigned FEAT_FPU = 0, FEAT_F16 = 1, FEAT_F16ALT = 2, FEAT_F8 = 3;
  localparam int unsigned FEAT_FVEC = 4, FEAT_CVXIF = 5, FEAT_CEXT = 6, FEAT_AEXT = 7;
  localparam int unsigned FEAT_FETCHUSER = 8, FEAT_DATAUSER = 9, FEAT_RENAME = 10, FEAT_FPGA = 11;
  localparam bit CFG_FPU = 1'b0, CFG_F16 = 1'b0, CFG_F16ALT = 1'b0, CFG_F8 = 1'b0;
  localparam bit CFG_FVEC = 1'b0, CFG_CVXIF = 1'b0, CFG_CEXT = 1'b0, CFG_AEXT = 1'b1;
  localparam bit CFG_FETCHUSER = 1'b0, CFG_DATAUSER = 1'b0, CFG_RENAME = 1'b0, CFG_FPGA = 1'b0;
  localparam logic [31:0] CFG_FEATURES =
    (32'(CFG_FPU) << FEAT_FPU) | (32'(CFG_F16) << FEAT_F16) | (32'(CFG_F16ALT) << FEAT_F16ALT) |
    (32'(CFG_F8) << FEAT_F8) | (32'(CFG_FVEC) << FEAT_FVEC) | (32'(CFG_CVXIF) << FEAT_CVXIF) |
    (32'(CFG_CEXT) << FEAT_CEXT) | (32'(CFG_AEXT) << FEAT_AEXT) |
    (32'(CFG_FETCHUSER) << FEAT_FETCHUSER) | (32'(CFG_DATAUSER) << FEAT_DATAUSER) |
    (32'(CFG_RENAME) << FEAT_RENAME) | (32'(CFG_FPGA) << FEAT_FPGA);
  localparam logic [31:0] CFG_SIG_SEED = 32'hC0F6_0000;
  typedef enum logic {DUMP_IDLE, DUMP_STREAM} dump_state_e;
  function automatic logic [31:0] cfg_base(input int unsigned idx);
    case (idx)
      CFG_IDX_XLEN:   return 32'd32;
      CFG_IDX_FEAT:   return CFG_FEATURES;
      CFG_IDX_FUSER:  return 32'd32;
      CFG_IDX_DUSER:  return 32'd32;
      CFG_IDX_ICACHE: return 32'd4;
      CFG_IDX_DCACHE: return 32'd8;
      CFG_IDX_COMMIT: return 32'd2;
      CFG_IDX_SB:     return 32'd8;
      CFG_IDX_LDPIPE: return 32'd1;
      CFG_IDX_STPIPE: return 32'd0;
      CFG_IDX_ITLB:   return 32'd16;
      CFG_IDX_DTLB:   return 32'd16;
      default:        return '0;
    endcase
  endfunction
  // Out-of-range indices read as zero; the signature folds in every base word.
  function automatic logic [31:0] cfg_word(input int unsigned idx);
    logic [31:0] sig;
    sig = CFG_SIG_SEED;
    for (int unsigned i = 0; i < CFG_IDX_SIG; i++) sig ^= cfg_base(i);
    return idx >= NUM_WORDS ? '0 : idx == CFG_IDX_SIG ? sig : cfg_base(idx);
  endfunction
endpackage

// File: rtl/cva6_cfg_dump_fsm.sv
// cva6_cfg_dump_fsm: streams every configuration word in index order over valid/ready
// Ports: clk_i, rst_ni (sync, active-low), start_i pulse, ready_i sink ready;
//        valid_o/data_o/idx_o/last_o stream word, busy_o dump in progress.
// Word count follows NUM_WORDS, which CVA6_CFG_SIGNATURE_EN extends.
module cva6_cfg_dump_fsm
  import cva6_cfg_reader_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned IDX_W  = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              ready_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic [IDX_W-1:0]  idx_o,
  output logic              last_o,
  output logic              busy_o
);
  dump_state_e state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic last_q, last_d, hs;
  assign valid_o = state_q == DUMP_STREAM;
  assign busy_o  = state_q == DUMP_STREAM;
  assign data_o  = data_q;
  assign idx_o   = cnt_q;
  assign last_o  = last_q;
  // Start is only looked at in IDLE, so a pulse on the final handshake is dropped.
  always_comb begin
    hs      = valid_o & ready_i;
    state_d = state_q == DUMP_IDLE ? (start_i ? DUMP_STREAM : DUMP_IDLE)
                                   : (hs & last_q ? DUMP_IDLE : DUMP_STREAM);
    cnt_d   = state_q == DUMP_IDLE ? '0 : (hs & ~last_q ? cnt_q + 1'b1 : cnt_q);
    data_d  = state_d == DUMP_STREAM ? DATA_W'(cfg_word(32'(cnt_d))) : '0;
    last_d  = state_d == DUMP_STREAM && cnt_d == IDX_W'(NUM_WORDS - 1);
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= DUMP_IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      last_q  <= last_d;
    end
  end
endmodule

// File: rtl/cva6_cfg_reader.sv
// cva6_cfg_reader: read-side responder exposing the core configuration as 32-bit words
// Ports: clk_i, rst_ni (sync, active-low);
//        read port req_i/idx_i/gnt_o -> rvalid_o/rdata_o/rerr_o, consumed by rready_i;
//        dump stream dump_start_i -> dump_valid_o/data_o/idx_o/last_o, dump_ready_i, dump_busy_o.
// Macro CVA6_CFG_SIGNATURE_EN adds a readable/dumped signature word at index 12.
module cva6_cfg_reader
  import cva6_cfg_reader_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned IDX_W  = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_i,
  input  logic [IDX_W-1:0]  idx_i,
  output logic              gnt_o,
  output logic              rvalid_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              rerr_o,
  input  logic              rready_i,
  input  logic              dump_start_i,
  output logic              dump_valid_o,
  output logic [DATA_W-1:0] dump_data_o,
  output logic [IDX_W-1:0]  dump_idx_o,
  output logic              dump_last_o,
  input  logic              dump_ready_i,
  output logic              dump_busy_o
);
  logic rvalid_q, rvalid_d, rerr_q, rerr_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  // Gated by reset so every output reads zero while rst_ni is low.
  assign gnt_o    = rst_ni & req_i & (~rvalid_q | rready_i);
  assign rvalid_o = rvalid_q;
  assign rdata_o  = rdata_q;
  assign rerr_o   = rerr_q;
  always_comb begin
    rvalid_d = gnt_o | (rvalid_q & ~rready_i);
    rdata_d  = gnt_o ? DATA_W'(cfg_word(32'(idx_i))) : rdata_q;
    rerr_d   = gnt_o ? 32'(idx_i) >= NUM_WORDS : rerr_q;
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rerr_q   <= 1'b0;
    end else begin
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      rerr_q   <= rerr_d;
    end
  end
  cva6_cfg_dump_fsm #(.DATA_W(DATA_W), .IDX_W(IDX_W)) u_dump (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .start_i (dump_start_i),
    .ready_i (dump_ready_i),
    .valid_o (dump_valid_o),
    .data_o  (dump_data_o),
    .idx_o   (dump_idx_o),
    .last_o  (dump_last_o),
    .busy_o  (dump_busy_o)
  );
endmodule

// File: tb/tb_cva6_cfg_reader.sv
// tb_cva6_cfg_reader: self-checking bench for the configuration reader
module tb_cva6_cfg_reader;
`ifdef CVA6_CFG_SIGNATURE_EN
  localparam int NUMW = 13;
`else
  localparam int NUMW = 12;
`endif
  logic clk = 1'b0, rst_ni = 1'b0;
  logic req = 1'b0, rready = 1'b0, dump_start = 1'b0, dump_ready = 1'b0;
  logic [3:0] idx = '0;
  logic gnt_o, rvalid_o, rerr_o, dump_valid_o, dump_last_o, dump_busy_o;
  logic [31:0] rdata_o, dump_data_o;
  logic [3:0] dump_idx_o;
  int total = 0, bad = 0;
  logic [31:0] cfg_vals [13];
  typedef struct {logic [3:0] idx; logic [31:0] data; logic err;} rd_vec_t;
  rd_vec_t vecs [8];

  cva6_cfg_reader dut (
    .clk_i(clk), .rst_ni(rst_ni), .req_i(req), .idx_i(idx), .gnt_o(gnt_o),
    .rvalid_o(rvalid_o), .rdata_o(rdata_o), .rerr_o(rerr_o), .rready_i(rready),
    .dump_start_i(dump_start), .dump_valid_o(dump_valid_o), .dump_data_o(dump_data_o),
    .dump_idx_o(dump_idx_o), .dump_last_o(dump_last_o), .dump_ready_i(dump_ready),
    .dump_busy_o(dump_busy_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", n, a, e, $time);
    end
  endtask

  function automatic logic [31:0] model_word(input int i);
    return i < NUMW ? cfg_vals[i] : 32'd0;
  endfunction

  task automatic chk_zero(input string n);
    chk({n, "_gnt"}, 32'(gnt_o), 0);
    chk({n, "_rvalid"}, 32'(rvalid_o), 0);
    chk({n, "_rdata"}, rdata_o, 0);
    chk({n, "_rerr"}, 32'(rerr_o), 0);
    chk({n, "_dvalid"}, 32'(dump_valid_o), 0);
    chk({n, "_ddata"}, dump_data_o, 0);
    chk({n, "_didx"}, 32'(dump_idx_o), 0);
    chk({n, "_dlast"}, 32'(dump_last_o), 0);
    chk({n, "_dbusy"}, 32'(dump_busy_o), 0);
  endtask

  task automatic do_read(input logic [3:0] i, input logic [31:0] ed, input logic ee, input int hold);
    @(negedge clk);
    req = 1'b1; idx = i; rready = 1'b1;
    #1 chk("rd_gnt", 32'(gnt_o), 1);
    @(negedge clk);
    req = 1'b0; rready = 1'b0;
    for (int h = 0; h <= hold; h++) begin
      if (h > 0) @(negedge clk);
      chk("rd_valid", 32'(rvalid_o), 1);
      chk("rd_data", rdata_o, ed);
      chk("rd_err", 32'(rerr_o), 32'(ee));
    end
    rready = 1'b1;
  endtask

  task automatic run_dump(input int ready_pct, input bit noisy_start);
    int k = 0, cyc = 0;
    bit done = 0;
    @(negedge clk);
    dump_start = 1'b1; dump_ready = 1'b0;
    @(negedge clk);
    dump_start = 1'b0;
    chk("dump_busy_rise", 32'(dump_busy_o), 1);
    while (!done && cyc < 400) begin
      cyc++;
      chk("dump_valid", 32'(dump_valid_o), 1);
      chk("dump_idx", 32'(dump_idx_o), 32'(k));
      chk("dump_data", dump_data_o, model_word(k));
      chk("dump_last", 32'(dump_last_o), 32'(k == NUMW - 1));
      dump_ready = $urandom_range(0, 99) < ready_pct;
      if (noisy_start) dump_start = 1'($urandom_range(0, 1));
      if (dump_valid_o && dump_ready) begin
        done = k == NUMW - 1;
        k++;
      end
      @(negedge clk);
    end
    dump_start = 1'b0; dump_ready = 1'b0;
    chk("dump_words", 32'(k), 32'(NUMW));
    chk("dump_busy_fall", 32'(dump_busy_o), 0);
    chk("dump_valid_fall", 32'(dump_valid_o), 0);
    @(negedge clk);
    chk("dump_stays_idle", 32'(dump_busy_o), 0);
  endtask

  initial begin
    cfg_vals = '{32, 32'h80, 32, 32, 4, 8, 2, 8, 1, 0, 16, 16, 0};
    cfg_vals[12] = 32'hC0F6_0000;
    for (int i = 0; i < 12; i++) cfg_vals[12] = cfg_vals[12] ^ cfg_vals[i];
    vecs[0] = '{4'd0, 32'd32, 1'b0};
    vecs[1] = '{4'd1, 32'h80, 1'b0};
    vecs[2] = '{4'd5, 32'd8, 1'b0};
    vecs[3] = '{4'd10, 32'd16, 1'b0};
    vecs[4] = '{4'd15, 32'd0, 1'b1};
`ifdef CVA6_CFG_SIGNATURE_EN
    vecs[5] = '{4'd12, 32'hC0F6_00A7, 1'b0};
`else
    vecs[5] = '{4'd12, 32'd0, 1'b1};
`endif
    vecs[6] = '{4'd11, 32'd16, 1'b0};
    vecs[7] = '{4'd13, 32'd0, 1'b1};
    req = 1'b1;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    req = 1'b0; rst_ni = 1'b1;
    @(negedge clk);
    chk("idle_rvalid", 32'(rvalid_o), 0);
    chk("idle_busy", 32'(dump_busy_o), 0);
    for (int v = 0; v < 8; v++) do_read(vecs[v].idx, vecs[v].data, vecs[v].err, v % 3);
    @(negedge clk);
    req = 1'b0; rready = 1'b1;
    @(negedge clk);
    chk("rd_valid_clear", 32'(rvalid_o), 0);
    // backpressure: response must stay put while rready is low
    req = 1'b1; idx = 4'd5; rready = 1'b1;
    #1 chk("bp_gnt0", 32'(gnt_o), 1);
    @(negedge clk);
    idx = 4'd3; rready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1 chk("bp_gnt_low", 32'(gnt_o), 0);
      chk("bp_valid", 32'(rvalid_o), 1);
      chk("bp_data", rdata_o, 32'd8);
      chk("bp_err", 32'(rerr_o), 0);
      @(negedge clk);
    end
    rready = 1'b1;
    #1 chk("bp_gnt_release", 32'(gnt_o), 1);
    @(negedge clk);
    req = 1'b0;
    chk("bp_next_valid", 32'(rvalid_o), 1);
    chk("bp_next_data", rdata_o, 32'd32);
    @(negedge clk);
    chk("bp_drain", 32'(rvalid_o), 0);
    run_dump(100, 1'b0);
    run_dump(40, 1'b1);
    // dump and random reads together
    fork
      run_dump(55, 1'b1);
      for (int r = 0; r < 30; r++) begin
        logic [3:0] ri;
        ri = 4'($urandom_range(0, 15));
        do_read(ri, model_word(int'(ri)), ri >= NUMW, $urandom_range(0, 2));
      end
    join
    // reset mid-dump with a pending response
    @(negedge clk);
    req = 1'b1; idx = 4'd6; rready = 1'b1;
    @(negedge clk);
    req = 1'b0; rready = 1'b0;
    dump_start = 1'b1; dump_ready = 1'b1;
    @(negedge clk);
    dump_start = 1'b0;
    for (int w = 0; w < 50 && dump_idx_o != 4'd5; w++) @(negedge clk);
    chk("mid_idx5", 32'(dump_idx_o), 5);
    chk("mid_rvalid", 32'(rvalid_o), 1);
    rst_ni = 1'b0; dump_ready = 1'b0; req = 1'b1;
    @(negedge clk);
    chk_zero("mid_reset");
    rst_ni = 1'b1; req = 1'b0; dump_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("post_reset_dvalid", 32'(dump_valid_o), 0);
      chk("post_reset_rvalid", 32'(rvalid_o), 0);
    end
    run_dump(70, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
